sysmem_bus_bridge: RTL and testbench

//  Initiator side of the on-chip system RAM: converts the picorv32 native memory bus
//  (valid/ready, 32-bit, byte strobes) into accesses on four 1024x8 single-port byte-lane

---
 rtl/sysmem_bus_bridge_pkg.sv | 15 +
 rtl/sysmem_bus_bridge_if.sv | 23 ++
 rtl/sysmem_bus_bridge.sv | 113 +++++++++++
 tb/tb_sysmem_bus_bridge.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sysmem_bus_bridge_pkg.sv
// Shared definitions for the picorv32-to-sysmem bridge: FSM encoding and lane geometry.
package sysmem_bus_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  localparam int READ_LATENCY_DEF = 2;
  localparam int NUM_LANES        = 4;
  localparam int LANE_WIDTH       = 8;
  localparam int DATA_WIDTH       = NUM_LANES * LANE_WIDTH;

endpackage

// File: rtl/sysmem_bus_bridge_if.sv
// picorv32 native memory bus: the CPU drives the master side, the RAM bridge the slave side.
interface sysmem_bus_bridge_if;
  import sysmem_bus_bridge_pkg::*;

  logic                  mem_valid;
  logic                  mem_instr;
  logic [31:0]           mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NUM_LANES-1:0]  mem_wstrb;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );

endinterface

// File: rtl/sysmem_bus_bridge.sv
// Converts picorv32 valid/ready requests into accesses on four byte-lane BRAMs with
// registered outputs; one transaction in flight, out-of-window accesses flag bus_err.
module sysmem_bus_bridge
  import sysmem_bus_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int          ADDR_WIDTH   = 10,
  parameter int          READ_LATENCY = READ_LATENCY_DEF
) (
  input  logic                  clk,
  input  logic                  resetn,
  sysmem_bus_bridge_if.slave    bus,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [NUM_LANES-1:0]  ram_ce,
  output logic [NUM_LANES-1:0]  ram_we,
  output logic [DATA_WIDTH-1:0] ram_di,
  output logic                  ram_rst,
  input  logic [DATA_WIDTH-1:0] ram_do,
  output logic                  bus_err
);

  localparam int CNT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt;
  logic                  hit;
  logic                  rd_done;
  logic [NUM_LANES-1:0]  lane_ce, lane_we;
  logic                  ready_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  unused_inputs;

  assign hit      = (bus.mem_addr[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
  assign rd_done  = (state == RD_WAIT) && (cnt == CNT_W'(READ_LATENCY));
  assign ram_addr = bus.mem_addr[ADDR_WIDTH+1:2];
  assign ram_di   = bus.mem_wdata;
  assign ram_rst  = ~resetn;

  // Lane strobes are gated by resetn so a request held during reset never reaches the RAM
  assign ram_ce   = lane_ce & {NUM_LANES{resetn}};
  assign ram_we   = lane_we & {NUM_LANES{resetn}};

  assign bus.mem_ready = ready_q;
  assign bus.mem_rdata = rdata_q;

  assign unused_inputs = ^{bus.mem_instr, bus.mem_addr[1:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    lane_ce   = '0;
    lane_we   = '0;
    case (state)
      IDLE: begin
        if (bus.mem_valid) begin
          if (!hit) begin
            state_nxt = RESP;
          end else if (|bus.mem_wstrb) begin
            lane_ce   = bus.mem_wstrb;
            lane_we   = bus.mem_wstrb;
            state_nxt = RESP;
          end else begin
            lane_ce   = '1;
            state_nxt = RD_WAIT;
          end
        end
      end
      RD_WAIT: if (rd_done) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Response path: ready is a single-cycle pulse; rdata only moves on read completion or a miss
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt     <= '0;
      ready_q <= 1'b0;
      rdata_q <= '0;
      bus_err <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mem_valid) begin
            if (!hit) begin
              rdata_q <= '0;
              ready_q <= 1'b1;
              bus_err <= 1'b1;
            end else if (|bus.mem_wstrb) begin
              ready_q <= 1'b1;
            end else begin
              cnt <= CNT_W'(1);
            end
          end
        end
        RD_WAIT: begin
          cnt <= cnt + CNT_W'(1);
          if (rd_done) begin
            rdata_q <= ram_do;
            ready_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sysmem_bus_bridge.sv
// Directed bench for sysmem_bus_bridge with a behavioural model of four OUTREG byte-lane BRAMs.
module tb_sysmem_bus_bridge;

  logic        clk = 1'b0;
  logic        resetn;
  logic [9:0]  ram_addr;
  logic [3:0]  ram_ce, ram_we;
  logic [31:0] ram_di;
  logic        ram_rst;
  logic [31:0] ram_do;
  logic        bus_err;

  int vectors = 0;
  int miscompares = 0;

  sysmem_bus_bridge_if bus ();

  sysmem_bus_bridge dut (
    .clk      (clk),
    .resetn   (resetn),
    .bus      (bus),
    .ram_addr (ram_addr),
    .ram_ce   (ram_ce),
    .ram_we   (ram_we),
    .ram_di   (ram_di),
    .ram_rst  (ram_rst),
    .ram_do   (ram_do),
    .bus_err  (bus_err)
  );

  always #5 clk = ~clk;

  // Byte-lane RAM model: address captured on ce, data appears one edge later on the output register
  logic [7:0] lane_mem   [4][1024];
  logic [7:0] lane_stage [4];

  always @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (ram_rst) begin
        lane_stage[n]    <= 8'h00;
        ram_do[8*n +: 8] <= 8'h00;
      end else begin
        if (ram_ce[n] && ram_we[n])  lane_mem[n][ram_addr] <= ram_di[8*n +: 8];
        if (ram_ce[n] && !ram_we[n]) lane_stage[n] <= lane_mem[n][ram_addr];
        ram_do[8*n +: 8] <= lane_stage[n];
      end
    end
  end

  task automatic test_reset();
    resetn        = 1'b0;
    bus.mem_valid = 1'b1;
    bus.mem_instr = 1'b0;
    bus.mem_addr  = 32'h0000_0010;
    bus.mem_wdata = 32'hA5A5_A5A5;
    bus.mem_wstrb = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (bus.mem_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ready: got %b, expected 0", bus.mem_ready); end
    vectors++; if (ram_ce !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_ce: got %h, expected 0", ram_ce); end
    vectors++; if (ram_we !== 4'h0) begin miscompares++; $display("[TB] FAIL reset_we: got %h, expected 0", ram_we); end
    vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_bus_err: got %b, expected 0", bus_err); end
    vectors++; if (bus.mem_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_rdata: got %h, expected 0", bus.mem_rdata); end
    vectors++; if (ram_rst !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_ram_rst: got %b, expected 1", ram_rst); end
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
    resetn        = 1'b1;
    @(negedge clk); #1;
    vectors++; if (bus.mem_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_ready: got %b, expected 0", bus.mem_ready); end
    vectors++; if (ram_rst !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_ram_rst: got %b, expected 0", ram_rst); end
  endtask

  task automatic test_write_read();
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h0000_0010;
    bus.mem_wdata = 32'hDEAD_BEEF;
    bus.mem_wstrb = 4'hF;
    #1;
    vectors++; if (ram_ce !== 4'hF) begin miscompares++; $display("[TB] FAIL wr_ce: got %h, expected f", ram_ce); end
    vectors++; if (ram_we !== 4'hF) begin miscompares++; $display("[TB] FAIL wr_we: got %h, expected f", ram_we); end
    vectors++; if (ram_addr !== 10'h004) begin miscompares++; $display("[TB] FAIL wr_addr: got %h, expected 004", ram_addr); end
    vectors++; if (ram_di !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL wr_di: got %h, expected deadbeef", ram_di); end
    @(negedge clk); #1;
    vectors++; if (bus.mem_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL wr_ready: got %b, expected 1", bus.mem_ready); end
    vectors++; if (ram_ce !== 4'h0) begin miscompares++; $display("[TB] FAIL wr_resp_ce: got %h, expected 0", ram_ce); end
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
    @(negedge clk); #1;
    vectors++; if (bus.mem_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL wr_ready_drop: got %b, expected 0", bus.mem_ready); end

    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h0000_0010;
    #1;
    vectors++; if (ram_ce !== 4'hF) begin miscompares++; $display("[TB] FAIL rd_ce: got %h, expected f", ram_ce); end
    vectors++; if (ram_we !== 4'h0) begin miscompares++; $display("[TB] FAIL rd_we: got %h, expected 0", ram_we); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      vectors++; if (bus.mem_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_early_ready cycle %0d: got %b, expected 0", c, bus.mem_ready); end
    end
    @(negedge clk); #1;
    vectors++; if (bus.mem_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rd_ready: got %b, expected 1", bus.mem_ready); end
    vectors++; if (bus.mem_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL rd_data: got %h, expected deadbeef", bus.mem_rdata); end
    bus.mem_valid = 1'b0;
    @(negedge clk); #1;
    vectors++; if (bus.mem_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rd_ready_drop: got %b, expected 0", bus.mem_ready); end
    vectors++; if (bus.mem_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL rd_data_hold: got %h, expected deadbeef", bus.mem_rdata); end
  endtask

  task automatic test_partial_write();
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h0000_0010;
    bus.mem_wdata = 32'h1122_3344;
    bus.mem_wstrb = 4'b0101;
    #1;
    vectors++; if (ram_ce !== 4'b0101) begin miscompares++; $display("[TB] FAIL pw_ce: got %b, expected 0101", ram_ce); end
    vectors++; if (ram_we !== 4'b0101) begin miscompares++; $display("[TB] FAIL pw_we: got %b, expected 0101", ram_we); end
    @(negedge clk); #1;
    vectors++; if (bus.mem_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL pw_ready: got %b, expected 1", bus.mem_ready); end
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
    @(negedge clk);
    bus.mem_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (bus.mem_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL pw_rd_ready: got %b, expected 1", bus.mem_ready); end
    vectors++; if (bus.mem_rdata !== 32'hDE22_BE44) begin miscompares++; $display("[TB] FAIL pw_rd_data: got %h, expected de22be44", bus.mem_rdata); end
    bus.mem_valid = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_window_edge();
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h0000_0FFC;
    bus.mem_wdata = 32'hCAFE_F00D;
    bus.mem_wstrb = 4'hF;
    #1;
    vectors++; if (ram_addr !== 10'h3FF) begin miscompares++; $display("[TB] FAIL edge_addr: got %h, expected 3ff", ram_addr); end
    vectors++; if (ram_ce !== 4'hF) begin miscompares++; $display("[TB] FAIL edge_ce: got %h, expected f", ram_ce); end
    @(negedge clk);
    bus.mem_valid = 1'b0;
    bus.mem_wstrb = 4'h0;
    @(negedge clk);
    bus.mem_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (bus.mem_rdata !== 32'hCAFE_F00D || bus.mem_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL edge_rd: got %h ready %b, expected cafef00d ready 1", bus.mem_rdata, bus.mem_ready); end
    bus.mem_valid = 1'b0;
    @(negedge clk); #1;
  endtask

  task automatic test_out_of_window();
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h0000_1000;
    bus.mem_wstrb = 4'h0;
    #1;
    vectors++; if (ram_ce !== 4'h0) begin miscompares++; $display("[TB] FAIL oow_ce: got %h, expected 0", ram_ce); end
    @(negedge clk); #1;
    vectors++; if (bus.mem_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL oow_ready: got %b, expected 1", bus.mem_ready); end
    vectors++; if (bus.mem_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL oow_rdata: got %h, expected 0", bus.mem_rdata); end
    vectors++; if (bus_err !== 1'b1) begin miscompares++; $display("[TB] FAIL oow_bus_err: got %b, expected 1", bus_err); end
    vectors++; if (ram_ce !== 4'h0) begin miscompares++; $display("[TB] FAIL oow_resp_ce: got %h, expected 0", ram_ce); end
    bus.mem_valid = 1'b0;
    @(negedge clk); #1;
    vectors++; if (bus.mem_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL oow_ready_drop: got %b, expected 0", bus.mem_ready); end
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h0000_0010;
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (bus.mem_rdata !== 32'hDE22_BE44) begin miscompares++; $display("[TB] FAIL oow_after_rd: got %h, expected de22be44", bus.mem_rdata); end
    vectors++; if (bus_err !== 1'b1) begin miscompares++; $display("[TB] FAIL oow_sticky: got %b, expected 1", bus_err); end
    bus.mem_valid = 1'b0;
    @(negedge clk); #1;
  endtask

  // Valid held high: RESP never strobes the lanes; the following IDLE cycle is a fresh request
  task automatic test_valid_held();
    logic [3:0] exp_ce  [4] = '{4'hF, 4'h0, 4'hF, 4'h0};
    logic       exp_rdy [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h0000_0020;
    bus.mem_wdata = 32'h0102_0304;
    bus.mem_wstrb = 4'hF;
    #1;
    for (int c = 0; c < 4; c++) begin
      vectors++; if (ram_ce !== exp_ce[c]) begin miscompares++; $display("[TB] FAIL held_ce cycle %0d: got %h, expected %h", c, ram_ce, exp_ce[c]); end
      vectors++; if (bus.mem_ready !== exp_rdy[c]) begin miscompares++; $display("[TB] FAIL held_ready cycle %0d: got %b, expected %b", c, bus.mem_ready, exp_rdy[c]); end
      if (c == 3) begin
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
      end
      @(negedge clk); #1;
    end
    vectors++; if (ram_ce !== 4'h0 || bus.mem_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL held_idle: got ce %h ready %b, expected ce 0 ready 0", ram_ce, bus.mem_ready); end
  endtask

  task automatic test_reset_mid_read();
    bus.mem_valid = 1'b1;
    bus.mem_addr  = 32'h0000_0010;
    bus.mem_wstrb = 4'h0;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      vectors++; if (bus.mem_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_ready cycle %0d: got %b, expected 0", c, bus.mem_ready); end
    end
    vectors++; if (bus_err !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_bus_err: got %b, expected 0", bus_err); end
    vectors++; if (bus.mem_rdata !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_rst_rdata: got %h, expected 0", bus.mem_rdata); end
    bus.mem_valid = 1'b0;
    resetn = 1'b1;
    repeat (2) begin
      @(negedge clk); #1;
      vectors++; if (bus.mem_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_rst_release_ready: got %b, expected 0", bus.mem_ready); end
    end
    bus.mem_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    vectors++; if (bus.mem_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL mid_rst_rd_ready: got %b, expected 1", bus.mem_ready); end
    vectors++; if (bus.mem_rdata !== 32'hDE22_BE44) begin miscompares++; $display("[TB] FAIL mid_rst_rd_data: got %h, expected de22be44", bus.mem_rdata); end
    bus.mem_valid = 1'b0;
    @(negedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_partial_write();
    test_window_edge();
    test_out_of_window();
    test_valid_held();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
